// File: rtl/datapath_sequencer_if.sv
// Bus bundle between the instruction sequencer, its instruction memory and the
// register-file/ALU datapath control inputs.
interface datapath_sequencer_if;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] reg_en;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [15:0] imm;
    logic [1:0]  b_sel;
    logic [3:0]  opcode;
    logic        flag_en;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output reg_en, reg_a, reg_b, imm, b_sel, opcode, flag_en, halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  reg_en, reg_a, reg_b, imm, b_sel, opcode, flag_en, halted
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Three-cycle fetch/decode/execute sequencer driving the register-file/ALU
// control slot from a synchronous instruction memory.
module datapath_sequencer (
    input  logic                   clk,
    input  logic                   rst,
    datapath_sequencer_if.master   bus
);
    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    localparam logic [3:0] MAJ_RTYPE = 4'h0;
    localparam logic [3:0] MAJ_FLAGS = 4'h1;
    localparam logic [3:0] MAJ_HALT  = 4'h3;
    localparam logic [3:0] MAJ_JUMP  = 4'h4;

    logic [1:0]  state_r;
    logic [7:0]  pc_r;
    logic [15:0] ir_r;
    logic        halted_r;

    logic [15:0] reg_en_r, reg_en_s;
    logic [3:0]  reg_a_r, reg_a_s;
    logic [3:0]  reg_b_r, reg_b_s;
    logic [15:0] imm_r, imm_s;
    logic [1:0]  b_sel_r, b_sel_s;
    logic [3:0]  opcode_r, opcode_s;
    logic        flag_en_r, flag_en_s;

    logic [15:0] word_s;
    logic [3:0]  rd_s;

    assign word_s = bus.imem_rdata;
    assign rd_s   = word_s[11:8];

    // Decode the word arriving from memory so the EXEC-cycle controls come straight from flops.
    always_comb begin
        reg_en_s  = 16'h0000;
        reg_a_s   = 4'h0;
        reg_b_s   = 4'h0;
        imm_s     = 16'h0000;
        b_sel_s   = 2'd0;
        opcode_s  = 4'h0;
        flag_en_s = 1'b0;
        if (state_r == ST_DECODE) begin
            case (word_s[15:12])
                MAJ_RTYPE: begin
                    reg_en_s  = 16'h0001 << rd_s;
                    reg_a_s   = rd_s;
                    reg_b_s   = word_s[3:0];
                    opcode_s  = word_s[7:4];
                    b_sel_s   = 2'd0;
                    flag_en_s = 1'b1;
                end
                MAJ_FLAGS: begin
                    reg_en_s  = 16'h0001 << rd_s;
                    reg_a_s   = rd_s;
                    opcode_s  = word_s[7:4];
                    b_sel_s   = 2'd2;
                    flag_en_s = 1'b0;
                end
                default: begin
                    if (word_s[15]) begin
                        reg_en_s  = 16'h0001 << rd_s;
                        reg_a_s   = rd_s;
                        imm_s     = {{8{word_s[7]}}, word_s[7:0]};
                        opcode_s  = {1'b0, word_s[14:12]};
                        b_sel_s   = 2'd1;
                        flag_en_s = 1'b1;
                    end else begin
                        // NOP, HALT, JUMP and reserved majors issue no datapath controls
                        reg_en_s  = 16'h0000;
                        flag_en_s = 1'b0;
                    end
                end
            endcase
        end else begin
            reg_en_s  = 16'h0000;
            flag_en_s = 1'b0;
        end
    end

    // Control output flops: loaded only on the DECODE->EXEC edge, so they pulse for EXEC alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_en_r  <= 16'h0000;
            reg_a_r   <= 4'h0;
            reg_b_r   <= 4'h0;
            imm_r     <= 16'h0000;
            b_sel_r   <= 2'd0;
            opcode_r  <= 4'h0;
            flag_en_r <= 1'b0;
        end else begin
            reg_en_r  <= reg_en_s;
            reg_a_r   <= reg_a_s;
            reg_b_r   <= reg_b_s;
            imm_r     <= imm_s;
            b_sel_r   <= b_sel_s;
            opcode_r  <= opcode_s;
            flag_en_r <= flag_en_s;
        end
    end

    // Sequencer state, program counter and instruction register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_FETCH;
            pc_r     <= 8'h00;
            ir_r     <= 16'h2000;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir_r    <= word_s;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (ir_r[15:12])
                        MAJ_HALT: begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end
                        MAJ_JUMP: begin
                            pc_r    <= ir_r[7:0];
                            state_r <= ST_FETCH;
                        end
                        default: begin
                            pc_r    <= pc_r + 8'd1;
                            state_r <= ST_FETCH;
                        end
                    endcase
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_addr = pc_r;
    assign bus.reg_en    = reg_en_r;
    assign bus.reg_a     = reg_a_r;
    assign bus.reg_b     = reg_b_r;
    assign bus.imm       = imm_r;
    assign bus.b_sel     = b_sel_r;
    assign bus.opcode    = opcode_r;
    assign bus.flag_en   = flag_en_r;
    assign bus.halted    = halted_r;
endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle instruction sequencer that sits directly upstream of the register-file/ALU datapath and drives its control inputs. It fetches 16-bit instructions from a synchronous instruction memory, decodes them and issues one datapath operation per instruction. The test-pattern generators are currently wired into that same control slot; this block replaces them so that programs, not hard-coded patterns, drive the datapath.

## Interface
Parameters:
- none; PC width fixed at 8, instruction width fixed at 16.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset asserted).
- imem_addr  out  8  instruction address; equals PC.
- imem_rdata  in  16  instruction word; synchronous memory, valid the cycle after imem_addr is presented.
- reg_en  out  16  one-hot register write enable (bit n writes Rn).
- reg_a  out  4  register-file read address A (ALU operand A).
- reg_b  out  4  register-file read address B.
- imm  out  16  sign-extended immediate.
- b_sel  out  2  ALU B mux select: 0 = register B, 1 = immediate, 2 = flags register.
- opcode  out  4  ALU opcode.
- flag_en  out  1  flags register load enable.
- halted  out  1  high once a HALT has executed.

## Operation
- Registers: pc[7:0], ir[15:0], state.
- States: FETCH -> DECODE -> EXEC -> FETCH; HALT is terminal.
  - FETCH: imem_addr = pc; memory samples the address at the end of the cycle.
  - DECODE: ir <= imem_rdata at the end of the cycle.
  - EXEC: decoded controls are driven; pc update at the end of the cycle.
- Instruction formats (ir[15:12] = major):
  - 4'h0 R-type: reg_a = ir[11:8] (Rd), reg_b = ir[3:0] (Rs), opcode = ir[7:4], b_sel = 0, reg_en = 1<<Rd, flag_en = 1.
  - 4'h1 flags-read: reg_a = Rd, opcode = ir[7:4], b_sel = 2, reg_en = 1<<Rd, flag_en = 0.
  - 4'h2 NOP: no enables.
  - 4'h3 HALT: no enables; next state HALT.
  - 4'h4 JUMP: pc <= ir[7:0]; no enables.
  - 4'h5-4'h7 reserved: executed as NOP.
  - 4'h8-4'hF I-type: opcode = {1'b0, ir[14:12]}, reg_a = Rd, imm = {{8{ir[7]}}, ir[7:0]}, b_sel = 1, reg_en = 1<<Rd, flag_en = 1.
- PC: pc <= pc + 1 in EXEC for every instruction except JUMP and HALT. Wraps 8'hFF -> 8'h00. HALT leaves pc at the HALT address.
- Outside EXEC, all of reg_en, flag_en, reg_a, reg_b, imm, b_sel and opcode are 0. Unused fields inside EXEC are also 0 (e.g. imm is 0 for R-type).
- Writes to R0 are permitted; there is no hard-wired zero register.
- HALT state: all enables 0 and halted = 1. Left only by reset.

## Timing
- Reset (rst low, asynchronous): state = FETCH, pc = 0, ir = 16'h2000, halted = 0. All control outputs 0 and imem_addr = 0 immediately on assertion.
- After rst deasserts, counting from the first rising edge:
  - cycle 0: FETCH, address 0.
  - cycle 1: DECODE.
  - cycle 2: EXEC; the register/flag write happens at the edge ending cycle 2.
- Throughput: 3 cycles per instruction.
- The enables are single-cycle pulses, exactly one per write instruction.
- imem_addr changes only at the edge ending EXEC. It is stable through FETCH and DECODE.
- halted rises at the edge ending HALT's EXEC cycle.
- Reset asserted mid-EXEC: enables drop to 0 immediately and no partial pc update occurs.
- JUMP to its own address loops forever: one fetch every 3 cycles, with no enables.

## Test plan
- Reset: hold rst low with arbitrary imem_rdata -> all outputs 0, imem_addr = 0, halted = 0. Release -> FETCH of address 0.
- R-type: mem[0] = 16'h0312 -> in cycle 2 only: reg_a = 3, reg_b = 2, opcode = 1, b_sel = 0, reg_en = 16'h0008, flag_en = 1. imem_addr = 1 in cycle 3.
- I-type sign extension: mem[0] = 16'hA5F0 -> opcode = 2, reg_a = 5, imm = 16'hFFF0, b_sel = 1, reg_en = 16'h0020. mem[1] = 16'h8107 -> imm = 16'h0007, opcode = 0.
- Flags-read and JUMP: 16'h1430 -> b_sel = 2, flag_en = 0, reg_en = 16'h0010. 16'h40FF -> next imem_addr = 8'hFF; a NOP at 8'hFF -> next imem_addr = 8'h00 (wrap).
- HALT: mem[2] = 16'h3000 -> halted = 1 from cycle 9. No further enables or imem_addr changes over 20 cycles. Reserved 16'h6xxx behaves as a NOP.
- Reset mid-EXEC: assert rst during an R-type EXEC cycle -> reg_en = 0 within the same cycle, pc = 0, and a clean restart from address 0.
